// File: rtl/rx_block_lock_if.sv
// Header bus between the RX gearbox and the block-lock controller.
// The gearbox side (master) supplies sync headers and receives slip
// requests. The controller side (slave) reports lock and invalid-header pulses.
interface rx_block_lock_if;
  logic       i_header_valid;
  logic [1:0] i_header;
  logic       o_slip;
  logic       o_block_lock;
  logic       o_sh_invalid;

  modport master (
    output i_header_valid, i_header,
    input  o_slip, o_block_lock, o_sh_invalid
  );

  modport slave (
    input  i_header_valid, i_header,
    output o_slip, o_block_lock, o_sh_invalid
  );
endinterface

// File: rtl/rx_block_lock.sv
// 10GBASE-R 64b/66b block synchronisation controller.
// It watches the 2-bit sync headers and asks the gearbox to bit-slip until
// 64 consecutive good headers are seen. It then holds block lock until a
// 64-header window contains 16 bad headers.
module rx_block_lock #(
  parameter int SH_CNT_MAX     = 64,
  parameter int SH_INVALID_MAX = 16,
  parameter int SLIP_WAIT      = 32
) (
  input  logic           i_clk,
  input  logic           i_reset,
  rx_block_lock_if.slave hdr
);

  localparam int CW = $clog2(SH_CNT_MAX + 1);
  localparam int IW = $clog2(SH_INVALID_MAX + 1);
  localparam int WW = $clog2(SLIP_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SH_CNT_MAX);
  localparam logic [IW-1:0] INV_MAX  = IW'(SH_INVALID_MAX);
  localparam logic [WW-1:0] WAIT_MAX = WW'(SLIP_WAIT);

  typedef enum logic [1:0] {
    ST_INIT, ST_TEST_SH, ST_SLIP, ST_SLIP_WAIT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] sh_cnt_q, sh_cnt_d;
  logic [IW-1:0] invld_q, invld_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          lock_q, lock_d;
  logic          slip_q, slip_d;
  logic          inv_q, inv_d;

  logic          bad_hdr;
  logic [CW-1:0] sh_inc;
  logic [IW-1:0] invld_inc;

  // Only 10 and 01 are legal sync headers.
  assign bad_hdr   = (hdr.i_header == 2'b00) || (hdr.i_header == 2'b11);
  // Saturating increments. The counters are cleared before they reach
  // the limit, but they must never wrap even so.
  assign sh_inc    = (sh_cnt_q == CNT_MAX) ? sh_cnt_q : sh_cnt_q + CW'(1);
  assign invld_inc = !bad_hdr ? invld_q :
                     (invld_q == INV_MAX) ? invld_q : invld_q + IW'(1);

  // State and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_INIT;
      sh_cnt_q <= '0;
      invld_q  <= '0;
      wait_q   <= '0;
      lock_q   <= 1'b0;
      slip_q   <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_cnt_q <= sh_cnt_d;
      invld_q  <= invld_d;
      wait_q   <= wait_d;
      lock_q   <= lock_d;
      slip_q   <= slip_d;
      inv_q    <= inv_d;
    end
  end

  // Next-state logic for the block-lock state machine.
  always_comb begin
    state_d  = state_q;
    sh_cnt_d = sh_cnt_q;
    invld_d  = invld_q;
    wait_d   = wait_q;
    lock_d   = lock_q;
    slip_d   = 1'b0;
    inv_d    = 1'b0;
    case (state_q)
      ST_INIT: begin
        sh_cnt_d = '0;
        invld_d  = '0;
        lock_d   = 1'b0;
        state_d  = ST_TEST_SH;
      end
      ST_TEST_SH: begin
        if (hdr.i_header_valid) begin
          inv_d = bad_hdr;
          if (!lock_q) begin
            // Acquisition needs an unbroken run of good headers.
            if (bad_hdr) begin
              state_d = ST_SLIP;
            end else if (sh_inc == CNT_MAX) begin
              lock_d   = 1'b1;
              sh_cnt_d = '0;
              invld_d  = '0;
            end else begin
              sh_cnt_d = sh_inc;
            end
          end else begin
            // Loss of lock takes priority over the end of the window. Lock
            // is dropped in SLIP so that it falls together with o_slip.
            if (invld_inc == INV_MAX) begin
              state_d  = ST_SLIP;
              sh_cnt_d = sh_inc;
              invld_d  = invld_inc;
            end else if (sh_inc == CNT_MAX) begin
              sh_cnt_d = '0;
              invld_d  = '0;
            end else begin
              sh_cnt_d = sh_inc;
              invld_d  = invld_inc;
            end
          end
        end
      end
      ST_SLIP: begin
        slip_d   = 1'b1;
        lock_d   = 1'b0;
        sh_cnt_d = '0;
        invld_d  = '0;
        wait_d   = WAIT_MAX;
        state_d  = ST_SLIP_WAIT;
      end
      ST_SLIP_WAIT: begin
        // Headers are discarded while the gearbox settles. Leave on the
        // cycle in which the count reaches zero.
        sh_cnt_d = '0;
        invld_d  = '0;
        wait_d   = (wait_q == '0) ? '0 : wait_q - WW'(1);
        if (wait_q <= WW'(1)) state_d = ST_TEST_SH;
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign hdr.o_slip       = slip_q;
  assign hdr.o_block_lock = lock_q;
  assign hdr.o_sh_invalid = inv_q;

endmodule

// File: tb/tb_rx_block_lock.sv
// Bench for rx_block_lock. Every cycle is compared against a behavioural
// model. The model tracks a good-run count, window counters and a
// "headers ignored for N more cycles" budget.
module tb_rx_block_lock;
  localparam int SH_CNT_MAX     = 64;
  localparam int SH_INVALID_MAX = 16;
  localparam int SLIP_WAIT      = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rx_block_lock_if bus();

  rx_block_lock #(
    .SH_CNT_MAX(SH_CNT_MAX), .SH_INVALID_MAX(SH_INVALID_MAX), .SLIP_WAIT(SLIP_WAIT)
  ) dut (
    .i_clk(clk), .i_reset(rst), .hdr(bus.slave)
  );

  int ntests = 0;
  int nfail  = 0;
  int nslips = 0;

  // Reference model state.
  logic m_locked, m_pend;
  int   m_good, m_win, m_bad, m_ignore;
  logic exp_slip, exp_lock, exp_inv;

  task automatic model(input logic r, input logic hv, input logic [1:0] h);
    logic bad;
    bad = (h == 2'b00) || (h == 2'b11);
    exp_slip = 1'b0;
    exp_inv  = 1'b0;
    if (r) begin
      m_locked = 0; m_pend = 0; m_good = 0; m_win = 0; m_bad = 0; m_ignore = 1;
    end else if (m_pend) begin
      m_pend = 0; exp_slip = 1'b1; m_locked = 0;
      m_good = 0; m_win = 0; m_bad = 0; m_ignore = SLIP_WAIT;
    end else if (m_ignore > 0) begin
      m_ignore--;
    end else if (hv) begin
      exp_inv = bad;
      if (!m_locked) begin
        if (bad) m_pend = 1;
        else begin
          m_good++;
          if (m_good == SH_CNT_MAX) begin m_locked = 1; m_good = 0; end
        end
      end else begin
        m_win++;
        if (bad) m_bad++;
        if (m_bad == SH_INVALID_MAX) m_pend = 1;
        else if (m_win == SH_CNT_MAX) begin m_win = 0; m_bad = 0; end
      end
    end
    exp_lock = m_locked;
  endtask

  task automatic check(input string tag, input logic got, input logic exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s t=%0t got %b exp %b", tag, $time, got, exp);
    end
  endtask

  // Drive one cycle, step the model on the edge and compare 1 ns later.
  task automatic cyc(input logic r, input logic hv, input logic [1:0] h);
    rst = r;
    bus.i_header_valid = hv;
    bus.i_header = h;
    @(posedge clk);
    model(r, hv, h);
    #1;
    check("slip", bus.o_slip, exp_slip);
    check("block_lock", bus.o_block_lock, exp_lock);
    check("sh_invalid", bus.o_sh_invalid, exp_inv);
    if (bus.o_slip === 1'b1) nslips++;
  endtask

  function automatic logic [1:0] good_hdr(input int k);
    return (k % 2) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
  endfunction

  task automatic do_reset();
    cyc(1'b1, 1'b0, 2'b00);
    cyc(1'b0, 1'b0, 2'b00);
  endtask

  task automatic feed_good(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, good_hdr(k));
  endtask

  initial begin
    int s0, off, budget, t;
    logic got_lock;
    bus.i_header_valid = 1'b0;
    bus.i_header = 2'b00;

    // Reset and acquisition with back-to-back good headers.
    cyc(1'b1, 1'b1, 2'b10);
    cyc(1'b1, 1'b0, 2'b00);
    check("rst_lock", bus.o_block_lock, 1'b0);
    check("rst_slip", bus.o_slip, 1'b0);
    check("rst_inv", bus.o_sh_invalid, 1'b0);
    cyc(1'b0, 1'b0, 2'b00);
    feed_good(63);
    check("t1_not_yet", bus.o_block_lock, 1'b0);
    cyc(1'b0, 1'b1, 2'b01);
    check("t1_lock", bus.o_block_lock, 1'b1);
    check("t1_noslip", nslips == 0, 1'b1);

    // Unlocked bad header: slip, blind window, then relock.
    do_reset();
    feed_good(10);
    s0 = nslips;
    cyc(1'b0, 1'b1, 2'b00);
    check("t2_inv", bus.o_sh_invalid, 1'b1);
    check("t2_slip_early", bus.o_slip, 1'b0);
    cyc(1'b0, 1'b1, 2'b10);
    check("t2_slip", bus.o_slip, 1'b1);
    for (int k = 0; k < SLIP_WAIT; k++)
      cyc(1'b0, 1'b1, (k % 5 == 2) ? 2'b11 : good_hdr(k));
    feed_good(64);
    check("t2_relock", bus.o_block_lock, 1'b1);
    check("t2_one_slip", (nslips - s0) == 1, 1'b1);

    // Locked: 15 bad in a window holds lock, 16 in the next one drops it.
    s0 = nslips;
    for (int p = 0; p < 64; p++) begin
      if ($urandom_range(0, 3) == 0) cyc(1'b0, 1'b0, bad_hdr());
      cyc(1'b0, 1'b1, (p % 4 == 1 && p < 60) ? bad_hdr() : good_hdr(p));
    end
    check("t3_held", bus.o_block_lock, 1'b1);
    for (int p = 0; p < 63; p++)
      cyc(1'b0, 1'b1, (p % 4 == 2) ? bad_hdr() : good_hdr(p));
    check("t3_lock_until_slip", bus.o_block_lock, 1'b1);
    cyc(1'b0, 1'b1, 2'b10);
    check("t3_lost", bus.o_block_lock, 1'b0);
    check("t3_slip", bus.o_slip, 1'b1);
    for (int k = 0; k < SLIP_WAIT; k++) cyc(1'b0, 1'b1, bad_hdr());
    feed_good(64);
    check("t3_relock", bus.o_block_lock, 1'b1);

    // Locked: the 16th bad header is also the 64th of the window.
    s0 = nslips;
    feed_good(48);
    for (int k = 0; k < 16; k++) cyc(1'b0, 1'b1, bad_hdr());
    check("t4_inv", bus.o_sh_invalid, 1'b1);
    cyc(1'b0, 1'b0, 2'b00);
    check("t4_slip", bus.o_slip, 1'b1);
    check("t4_lost", bus.o_block_lock, 1'b0);
    for (int k = 0; k < SLIP_WAIT; k++) cyc(1'b0, 1'b0, 2'b00);
    feed_good(64);
    check("t4_relock", bus.o_block_lock, 1'b1);

    // Gearbox model with a random number of slips to alignment.
    for (int trial = 0; trial < 4; trial++) begin
      do_reset();
      off = (trial == 0) ? 65 : $urandom_range(0, 65);
      budget = (off + 1) * (SLIP_WAIT + 2) + 64;
      got_lock = 1'b0;
      t = 0;
      while (!got_lock && t < budget) begin
        cyc(1'b0, 1'b1, (off == 0) ? good_hdr(t) : bad_hdr());
        if (bus.o_slip === 1'b1 && off > 0) off--;
        if (bus.o_block_lock === 1'b1) got_lock = 1'b1;
        t++;
      end
      check("gb_lock_in_bound", got_lock, 1'b1);
      s0 = nslips;
      for (int k = 0; k < 150; k++)
        cyc(1'b0, $urandom_range(0, 3) != 0, good_hdr(k));
      check("gb_no_more_slips", nslips == s0, 1'b1);
    end

    // Reset in the middle of SLIP_WAIT.
    do_reset();
    feed_good(5);
    cyc(1'b0, 1'b1, 2'b11);
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, 2'b10);
    cyc(1'b1, 1'b1, 2'b10);
    check("t6a_lock", bus.o_block_lock, 1'b0);
    check("t6a_slip", bus.o_slip, 1'b0);
    check("t6a_inv", bus.o_sh_invalid, 1'b0);
    cyc(1'b0, 1'b1, 2'b00);
    feed_good(64);
    check("t6a_relock", bus.o_block_lock, 1'b1);

    // Reset while locked.
    cyc(1'b0, 1'b1, 2'b00);
    cyc(1'b1, 1'b1, 2'b10);
    check("t6b_lock", bus.o_block_lock, 1'b0);
    check("t6b_slip", bus.o_slip, 1'b0);
    check("t6b_inv", bus.o_sh_invalid, 1'b0);
    cyc(1'b0, 1'b0, 2'b00);
    feed_good(64);
    check("t6b_relock", bus.o_block_lock, 1'b1);

    // Random traffic: gaps, sparse bad headers, occasional reset.
    for (int k = 0; k < 3000; k++)
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0,
          ($urandom_range(0, 39) == 0) ? bad_hdr() : good_hdr(k));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/rx_block_lock.md
# rx_block_lock

Receive-side 64b/66b block synchronisation controller for the 10GBASE-R PCS. It consumes the 2-bit sync header of each 66-bit block delivered by the RX gearbox and runs the Clause 49 block-lock state machine. It commands the gearbox to bit-slip until the header boundary is found, then asserts block lock to the descrambler and decoder. It drops lock after too many invalid headers in a window.

## Interface
- SH_CNT_MAX, 64: headers per test window; also the number of consecutive valid headers needed to acquire lock.
- SH_INVALID_MAX, 16: invalid headers within one window that force loss of lock while locked.
- SLIP_WAIT, 32: cycles during which headers are ignored after a slip, so the gearbox can re-align.
- Clock and reset: one clock; reset is synchronous and active-high.
- i_clk  in  1  PCS RX clock; all logic is on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_header_valid  in  1  i_header carries a new block header this cycle.
- i_header  in  2  sync header. 2'b10 (SYNC_DATA) and 2'b01 (SYNC_CTL) are valid; 2'b00 and 2'b11 are invalid.
- o_slip  out  1  one-cycle pulse; gearbox shifts its alignment by one bit.
- o_block_lock  out  1  block boundary acquired.
- o_sh_invalid  out  1  one-cycle pulse: the header sampled last cycle was invalid. Used by the BER monitor.

## Operation
- States: INIT, TEST_SH, SLIP, SLIP_WAIT.
- Counters:
  - sh_cnt, width $clog2(SH_CNT_MAX+1).
  - sh_invld_cnt, width $clog2(SH_INVALID_MAX+1).
  - wait_cnt, width $clog2(SLIP_WAIT+1).
  - All counters saturate and never wrap.
- INIT: clear sh_cnt and sh_invld_cnt; clear o_block_lock; go to TEST_SH on the next cycle.
- TEST_SH, unlocked: act only on cycles with i_header_valid.
  - Valid header: sh_cnt++.
  - When sh_cnt reaches SH_CNT_MAX, set o_block_lock and clear both counters.
  - Invalid header: go to SLIP immediately; a single bad header restarts acquisition.
- TEST_SH, locked: every header increments sh_cnt; each invalid header also increments sh_invld_cnt.
  - sh_invld_cnt reaches SH_INVALID_MAX: clear o_block_lock and go to SLIP.
  - Otherwise, sh_cnt reaches SH_CNT_MAX: clear both counters and stay locked.
  - If both limits are reached on the same header, loss of lock wins.
- SLIP: assert o_slip for exactly one cycle, clear o_block_lock and both counters, load wait_cnt, then go to SLIP_WAIT.
- SLIP_WAIT:
  - Decrement wait_cnt every cycle, regardless of i_header_valid.
  - All headers are discarded: no counting and no o_sh_invalid.
  - When wait_cnt reaches 0, go to TEST_SH with the counters cleared.
- o_sh_invalid pulses for every invalid header sampled in TEST_SH, in both the locked and unlocked condition.
- i_header is ignored whenever i_header_valid is 0.

## Timing
- Reset values: state INIT, o_block_lock=0, o_slip=0, o_sh_invalid=0, all counters 0.
- Reset is applied on the first i_clk edge with i_reset=1, including mid-slip or mid-wait. After reset deasserts, TEST_SH is entered 1 cycle later (via INIT).
- All outputs are registered.
- o_block_lock rises on the cycle after the SH_CNT_MAX-th consecutive valid header is sampled.
- Invalid header sampled at edge N in TEST_SH:
  - o_sh_invalid=1 in cycle N+1.
  - If that header causes a slip, state is SLIP in cycle N+1 and o_slip=1 in cycle N+2.
  - o_block_lock falls together with o_slip.
- Slip spacing: o_slip pulses are separated by at least SLIP_WAIT+2 cycles.
- Header-to-slip latency: 2 cycles, constant.
- Back-to-back i_header_valid on every cycle is supported at full rate.

## Test plan
- Reset then 64 valid headers (alternating 2'b10 and 2'b01), back to back -> o_block_lock=1 exactly one cycle after the 64th header; o_slip never asserted.
- Unlocked, 10 valid headers then 2'b00 -> o_sh_invalid pulse, o_slip single pulse 2 cycles later. The 32 following headers are ignored: inject 2'b11 during the wait and confirm no second o_slip. Then 64 valid headers -> lock.
- Locked, 15 invalid headers spread over one 64-header window -> lock held; the counter clears at the window end. Next window with 16 invalid headers -> o_block_lock=0 and o_slip pulse on the 16th.
- Locked, window where the 16th invalid header is also the 64th header -> loss of lock and slip (priority check).
- Gearbox model with random initial offset 0-65 -> lock within (offset+1) × (SLIP_WAIT+2) + 64 header periods. After lock, no further slips.
- Assert i_reset for 1 cycle during SLIP_WAIT, and separately while locked -> all outputs 0 on the next cycle; acquisition restarts from INIT.
